// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared FSM state encoding and operation-mode constants
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: request/result bundle between a requester and the serial adder
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (output start, mode, a, b, input busy, done, sum, cout, ovf, zero);
    modport slave  (input start, mode, a, b, output busy, done, sum, cout, ovf, zero);
endinterface

// File: rtl/serial_add_sub_add_digit.sv
// add_digit: combinational DIGIT-bit adder with carry out and carry into its top bit
module add_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    // The carry entering the top bit is recovered from that bit's sum and operands.
    assign cmsb = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial add/subtract with start/done handshake and status flags
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            rst_n,
    serial_add_sub_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_param
        $error("serial_add_sub: WIDTH must be 2..64 and a multiple of DIGIT");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q, res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cmsb_q, busy_q, done_q, cout_q, ovf_q, zero_q;
    logic [DIGIT-1:0] s;
    logic             c_out, c_msb;

    add_digit #(.DIGIT(DIGIT)) u_add (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (s),
        .cout (c_out),
        .cmsb (c_msb)
    );

    // New digit enters at the MSB side so the result is LSB-aligned after STEPS shifts.
    assign res_d = (res_q >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));

    // FSM and datapath: accept in IDLE/DONE, one digit per RUN cycle, latch results entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                        carry_q <= (bus.mode == MODE_SUB);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(STEPS)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_q;
                        cout_q  <= carry_q;
                        ovf_q   <= cmsb_q ^ carry_q;
                        zero_q  <= (res_q == '0);
                    end else begin
                        a_q     <= a_q >> DIGIT;
                        b_q     <= b_q >> DIGIT;
                        res_q   <= res_d;
                        carry_q <= c_out;
                        cmsb_q  <= c_msb;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule
